// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    FILTER    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } seq_state_e;

  localparam int RETRY_W = 8;

  // Bits needed to hold 0..count-1, never less than one.
  function automatic int cnt_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/lock_sync.sv
// Two-flop synchroniser bringing the asynchronous PLL lock into the reference clock domain.
module lock_sync (
  input  logic clk_in,
  input  logic rst_in_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta_r;
  logic sync_r;

  // Metastability stage followed by the stable sample.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= async_in;
      sync_r <= meta_r;
    end
  end

  assign sync_out = sync_r;

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset pulse, lock qualification and staged per-domain reset release.
// Define PLL_SEQ_TIMEOUT_EN to build the lock-timeout retry logic.
module pll_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int HOLD_CYCLES  = 16,
  parameter int LOCK_FILTER  = 64,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int N_DOMAINS    = 2,
  parameter int STAGE_GAP    = 128
) (
  input  logic                 clk_in,
  input  logic                 rst_in_n,
  input  logic                 pll_lock,
  input  logic                 soft_rst_req,
  output logic                 pll_rst,
  output logic [N_DOMAINS-1:0] domain_rst,
  output logic                 ready,
  output logic                 lock_lost,
  output logic [RETRY_W-1:0]   retry_count
);

  localparam int HOLD_W = cnt_width(HOLD_CYCLES);
  localparam int FILT_W = cnt_width(LOCK_FILTER);
  localparam int GAP_W  = cnt_width(STAGE_GAP);
  localparam int IDX_W  = cnt_width(N_DOMAINS);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DOMAINS - 1);

  seq_state_e           state_r, state_n;
  logic [HOLD_W-1:0]    hold_cnt_r, hold_cnt_n;
  logic [FILT_W-1:0]    filt_cnt_r, filt_cnt_n;
  logic [GAP_W-1:0]     gap_cnt_r, gap_cnt_n;
  logic [IDX_W-1:0]     idx_r, idx_n;
  logic [N_DOMAINS-1:0] domain_rst_n;
  logic                 ready_n;
  logic                 lock_lost_n;
  logic                 lock_s;
  logic                 loss_s;
  logic                 timeout_s;
  logic                 abort_s;

  lock_sync u_lock_sync (
    .clk_in   (clk_in),
    .rst_in_n (rst_in_n),
    .async_in (pll_lock),
    .sync_out (lock_s)
  );

`ifdef PLL_SEQ_TIMEOUT_EN
  localparam int TO_W = cnt_width(LOCK_TIMEOUT);
  localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = {RETRY_W{1'b1}};

  logic [TO_W-1:0]    to_cnt_r;
  logic [RETRY_W-1:0] retry_r;
  logic               waiting_s;

  assign waiting_s = (state_r == WAIT_LOCK) || (state_r == FILTER);
  assign timeout_s = waiting_s && (to_cnt_r == TO_LAST);

  // Timeout counter spans WAIT_LOCK and FILTER and restarts on each new attempt.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      to_cnt_r <= '0;
      retry_r  <= '0;
    end else begin
      to_cnt_r <= waiting_s ? (to_cnt_r + TO_W'(1)) : '0;
      if (timeout_s && (retry_r != RETRY_MAX)) begin
        retry_r <= retry_r + RETRY_W'(1);
      end
    end
  end

  assign retry_count = retry_r;
`else
  assign timeout_s   = 1'b0;
  assign retry_count = '0;
`endif

  // Loss of lock is only meaningful once domains have started coming out of reset.
  assign loss_s  = ((state_r == RELEASE) || (state_r == RUN)) && !lock_s;
  assign abort_s = loss_s || ((state_r != PLL_RST) && (soft_rst_req || timeout_s));

  // Next-state and next-output decode.
  always_comb begin
    state_n      = state_r;
    hold_cnt_n   = hold_cnt_r;
    filt_cnt_n   = filt_cnt_r;
    gap_cnt_n    = gap_cnt_r;
    idx_n        = idx_r;
    domain_rst_n = domain_rst;
    ready_n      = ready;
    lock_lost_n  = lock_lost | loss_s;
    if (abort_s) begin
      state_n      = PLL_RST;
      hold_cnt_n   = '0;
      filt_cnt_n   = '0;
      gap_cnt_n    = '0;
      idx_n        = '0;
      domain_rst_n = '1;
      ready_n      = 1'b0;
    end else begin
      case (state_r)
        PLL_RST: begin
          if (hold_cnt_r == HOLD_LAST) begin
            state_n    = WAIT_LOCK;
            hold_cnt_n = '0;
          end else begin
            hold_cnt_n = hold_cnt_r + HOLD_W'(1);
          end
        end
        WAIT_LOCK, FILTER: begin
          if (!lock_s) begin
            state_n    = WAIT_LOCK;
            filt_cnt_n = '0;
          end else if (filt_cnt_r != FILT_LAST) begin
            state_n    = FILTER;
            filt_cnt_n = filt_cnt_r + FILT_W'(1);
          end else begin
            // Qualified lock: domain 0 leaves reset on this very edge.
            state_n         = (N_DOMAINS == 1) ? RUN : RELEASE;
            filt_cnt_n      = '0;
            gap_cnt_n       = '0;
            idx_n           = IDX_W'(1);
            domain_rst_n[0] = 1'b0;
            ready_n         = (N_DOMAINS == 1);
          end
        end
        RELEASE: begin
          if (gap_cnt_r != GAP_LAST) begin
            gap_cnt_n = gap_cnt_r + GAP_W'(1);
          end else begin
            gap_cnt_n           = '0;
            domain_rst_n[idx_r] = 1'b0;
            if (idx_r == IDX_LAST) begin
              state_n = RUN;
              ready_n = 1'b1;
            end else begin
              idx_n = idx_r + IDX_W'(1);
            end
          end
        end
        RUN: begin
          state_n = RUN;
        end
        default: begin
          state_n = PLL_RST;
        end
      endcase
    end
  end

  // State, counters and glitch-free registered outputs.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_r    <= PLL_RST;
      hold_cnt_r <= '0;
      filt_cnt_r <= '0;
      gap_cnt_r  <= '0;
      idx_r      <= '0;
      pll_rst    <= 1'b1;
      domain_rst <= '1;
      ready      <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      state_r    <= state_n;
      hold_cnt_r <= hold_cnt_n;
      filt_cnt_r <= filt_cnt_n;
      gap_cnt_r  <= gap_cnt_n;
      idx_r      <= idx_n;
      pll_rst    <= (state_n == PLL_RST);
      domain_rst <= domain_rst_n;
      ready      <= ready_n;
      lock_lost  <= lock_lost_n;
    end
  end

endmodule
